// File: rtl/uart_tx_mmio_pkg.sv
// Shared types and constants for the memory-mapped UART transmitter.
package uart_tx_mmio_pkg;

  // Transmit framing FSM states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

  // Default byte addresses of the two registers.
  localparam logic [31:0] DEF_TX_ADDR   = 32'h0000_0100;
  localparam logic [31:0] DEF_STAT_ADDR = 32'h0000_0104;

  // Bit positions inside the status word.
  localparam int STAT_BUSY_BIT  = 0;
  localparam int STAT_FULL_BIT  = 1;
  localparam int STAT_EMPTY_BIT = 2;
  localparam int STAT_OVF_BIT   = 3;

  // Bit of the store data that clears the sticky overflow flag.
  localparam int CLR_OVF_BIT = 3;

  // Assemble the 32-bit status word from the individual flags.
  function automatic logic [31:0] pack_status(input logic ovf, input logic empty,
                                              input logic full, input logic busy);
    logic [31:0] v;
    v                 = '0;
    v[STAT_OVF_BIT]   = ovf;
    v[STAT_EMPTY_BIT] = empty;
    v[STAT_FULL_BIT]  = full;
    v[STAT_BUSY_BIT]  = busy;
    return v;
  endfunction

endpackage

// File: rtl/uart_tx_mmio_if.sv
// Store/load bus seen by the UART: core drives the access, UART returns status and hit.
interface uart_tx_mmio_if;
  logic        EN;
  logic [31:0] Address;
  logic [7:0]  RegData;
  logic [31:0] RData_out;
  logic        hit;

  modport master (
    output EN, Address, RegData,
    input  RData_out, hit
  );

  modport slave (
    input  EN, Address, RegData,
    output RData_out, hit
  );
endinterface

// File: rtl/uart_tx_mmio_sync_fifo4x8.sv
// Four-entry byte FIFO with a combinational head so the transmitter can pop
// and load its shift register on the same edge.
module sync_fifo4x8 (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       full,
  output logic       empty,
  output logic [2:0] count
);
  logic [1:0] r_wr_ptr;
  logic [1:0] r_rd_ptr;
  logic [2:0] r_count;
  logic [7:0] w_mem [4];
  logic       w_do_push;
  logic       w_do_pop;

  assign full      = (r_count == 3'd4);
  assign empty     = (r_count == 3'd0);
  assign count     = r_count;
  assign w_do_pop  = pop && !empty;
  // A pop on the same edge frees a slot, so a full FIFO still accepts the push.
  assign w_do_push = push && (!full || w_do_pop);
  assign dout      = w_mem[r_rd_ptr];

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_entry
      logic [7:0] r_data;
      // Slot captures the incoming byte only when the write pointer selects it.
      always_ff @(posedge clk) begin
        if (w_do_push && (r_wr_ptr == 2'(gi))) begin
          r_data <= din;
        end
      end
      assign w_mem[gi] = r_data;
    end
  endgenerate

  // Pointers wrap naturally at 4; occupancy tracks pushes minus pops.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= 2'd0;
      r_rd_ptr <= 2'd0;
      r_count  <= 3'd0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 2'd1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 2'd1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 3'd1;
        2'b01:   r_count <= r_count - 3'd1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_mmio.sv
// Memory-mapped UART transmitter: stores to TX_ADDR queue bytes into a small
// FIFO, a framing FSM shifts them out 8N1, and STAT_ADDR exposes status.
module uart_tx_mmio
  import uart_tx_mmio_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter logic [31:0] TX_ADDR      = DEF_TX_ADDR,
  parameter logic [31:0] STAT_ADDR    = DEF_STAT_ADDR
) (
  input  logic          clk,
  input  logic          rst,
  uart_tx_mmio_if.slave bus,
  output logic          UART_TXD
);
  localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

  tx_state_e   r_state;
  tx_state_e   w_state_next;
  logic [15:0] r_baud;
  logic [15:0] w_baud_next;
  logic [2:0]  r_bit_idx;
  logic [2:0]  w_bit_idx_next;
  logic [7:0]  r_shift;
  logic [7:0]  w_shift_next;
  logic        r_txd;
  logic        w_txd_next;
  logic        r_overflow;

  logic        w_tx_hit;
  logic        w_stat_hit;
  logic        w_push;
  logic        w_pop;
  logic        w_ovf_set;
  logic        w_ovf_clr;
  logic        w_baud_done;

  logic [7:0]  w_fifo_dout;
  logic        w_fifo_full;
  logic        w_fifo_empty;
  logic [2:0]  w_fifo_count;

  // Full-width decode; loads never touch state, only EN-qualified stores do.
  assign w_tx_hit   = (bus.Address == TX_ADDR);
  assign w_stat_hit = (bus.Address == STAT_ADDR);
  assign bus.hit    = w_tx_hit || w_stat_hit;
  assign w_push     = bus.EN && w_tx_hit;
  assign w_ovf_clr  = bus.EN && w_stat_hit && bus.RegData[CLR_OVF_BIT];
  // A byte is dropped only when the FIFO holds four entries and nothing leaves this edge.
  assign w_ovf_set  = w_push && !w_pop && (w_fifo_count == 3'd4);
  assign w_baud_done = (r_baud == BAUD_LAST);
  assign UART_TXD   = r_txd;

  sync_fifo4x8 u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .pop   (w_pop),
    .din   (bus.RegData),
    .dout  (w_fifo_dout),
    .full  (w_fifo_full),
    .empty (w_fifo_empty),
    .count (w_fifo_count)
  );

  // Status word is driven only while the status register is addressed.
  always_comb begin
    bus.RData_out = '0;
    if (w_stat_hit) begin
      bus.RData_out = pack_status(r_overflow, w_fifo_empty, w_fifo_full,
                                  r_state != ST_IDLE);
    end
  end

  // Framing FSM next-state: line level is registered, so each transition
  // also decides the level of the next bit.
  always_comb begin
    w_state_next   = r_state;
    w_baud_next    = r_baud + 16'd1;
    w_bit_idx_next = r_bit_idx;
    w_shift_next   = r_shift;
    w_txd_next     = r_txd;
    w_pop          = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_baud_next = 16'd0;
        if (!w_fifo_empty) begin
          w_pop        = 1'b1;
          w_shift_next = w_fifo_dout;
          w_state_next = ST_START;
          w_txd_next   = 1'b0;
        end
      end
      ST_START: begin
        if (w_baud_done) begin
          w_baud_next    = 16'd0;
          w_bit_idx_next = 3'd0;
          w_state_next   = ST_DATA;
          w_txd_next     = r_shift[0];
        end
      end
      ST_DATA: begin
        if (w_baud_done) begin
          w_baud_next = 16'd0;
          if (r_bit_idx == 3'd7) begin
            w_bit_idx_next = 3'd0;
            w_state_next   = ST_STOP;
            w_txd_next     = 1'b1;
          end else begin
            w_bit_idx_next = r_bit_idx + 3'd1;
            w_shift_next   = {1'b0, r_shift[7:1]};
            w_txd_next     = r_shift[1];
          end
        end
      end
      ST_STOP: begin
        if (w_baud_done) begin
          w_baud_next = 16'd0;
          // Chain straight into the next start bit when more data is waiting.
          if (!w_fifo_empty) begin
            w_pop        = 1'b1;
            w_shift_next = w_fifo_dout;
            w_state_next = ST_START;
            w_txd_next   = 1'b0;
          end else begin
            w_state_next = ST_IDLE;
            w_txd_next   = 1'b1;
          end
        end
      end
      default: begin
        w_state_next = ST_IDLE;
        w_baud_next  = 16'd0;
        w_txd_next   = 1'b1;
      end
    endcase
  end

  // Framing FSM registers; reset aborts any frame and returns the line high.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_baud    <= 16'd0;
      r_bit_idx <= 3'd0;
      r_shift   <= 8'd0;
      r_txd     <= 1'b1;
    end else begin
      r_state   <= w_state_next;
      r_baud    <= w_baud_next;
      r_bit_idx <= w_bit_idx_next;
      r_shift   <= w_shift_next;
      r_txd     <= w_txd_next;
    end
  end

  // Sticky overflow flag; a drop on the same edge as a clear keeps it set.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_overflow <= 1'b0;
    end else if (w_ovf_set) begin
      r_overflow <= 1'b1;
    end else if (w_ovf_clr) begin
      r_overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Bench for uart_tx_mmio: stimulus queues expected frames, a serial monitor
// decodes UART_TXD cycle by cycle and checks each frame against the queue.
`timescale 1ns/1ps
module tb_uart_tx_mmio;
  localparam int          CPB   = 4;
  localparam logic [31:0] TX_A  = 32'h0000_0100;
  localparam logic [31:0] ST_A  = 32'h0000_0104;
  localparam logic [31:0] BAD_A = 32'h0000_0108;

  typedef struct {
    logic [7:0] data;
    int         start;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic uart_txd;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  bit   mon_busy = 1'b0;
  exp_t exp_q[$];

  uart_tx_mmio_if bus_if();

  uart_tx_mmio #(
    .CLKS_PER_BIT (CPB),
    .TX_ADDR      (TX_A),
    .STAT_ADDR    (ST_A)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus_if.slave),
    .UART_TXD (uart_txd)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got=0x%08h want=0x%08h (cycle %0d)", name, act, want, cyc);
    end else begin
      $display("ok   %s: 0x%08h (cycle %0d)", name, act, cyc);
    end
  endtask

  task automatic expect_frame(input logic [7:0] d, input int start);
    exp_t e;
    e.data  = d;
    e.start = start;
    exp_q.push_back(e);
  endtask

  // One bus store; returns the cycle number of the edge that sampled it.
  task automatic bus_write(input logic [31:0] addr, input logic [7:0] data, output int edge_cyc);
    bus_if.Address = addr;
    bus_if.RegData = data;
    bus_if.EN      = 1'b1;
    @(posedge clk);
    #1;
    edge_cyc       = cyc;
    bus_if.EN      = 1'b0;
    bus_if.Address = '0;
    bus_if.RegData = '0;
  endtask

  task automatic read_status(input logic [3:0] want, input string name);
    bus_if.Address = ST_A;
    bus_if.EN      = 1'b0;
    @(negedge clk);
    check(name, bus_if.RData_out, {28'h0, want});
    check({name, "_hit"}, {31'h0, bus_if.hit}, 32'h1);
    @(posedge clk);
    #1;
    bus_if.Address = '0;
  endtask

  task automatic probe(input logic [31:0] addr, input logic want_hit, input string name);
    bus_if.Address = addr;
    bus_if.EN      = 1'b0;
    @(negedge clk);
    check({name, "_hit"}, {31'h0, bus_if.hit}, {31'h0, want_hit});
    check({name, "_data"}, bus_if.RData_out, 32'h0);
    @(posedge clk);
    #1;
    bus_if.Address = '0;
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_drain(input int budget, input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || mon_busy) && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    check(name, exp_q.size(), 0);
  endtask

  // Serial monitor: a falling line starts a 10-bit capture of CPB samples per bit.
  initial begin : monitor
    logic [39:0] smp;
    int          s0;
    logic [7:0]  got;
    bit          shape_ok;
    exp_t        e;
    forever begin
      @(negedge clk);
      if (rst === 1'b0 && uart_txd === 1'b0) begin
        mon_busy = 1'b1;
        s0       = cyc;
        smp[0]   = uart_txd;
        for (int i = 1; i < 40; i++) begin
          @(negedge clk);
          smp[i] = uart_txd;
        end
        shape_ok = 1'b1;
        for (int g = 0; g < 10; g++) begin
          for (int k = 1; k < CPB; k++) begin
            if (smp[CPB*g+k] !== smp[CPB*g]) shape_ok = 1'b0;
          end
        end
        if (smp[36] !== 1'b1) shape_ok = 1'b0;
        for (int b = 0; b < 8; b++) got[b] = smp[CPB*(b+1)];
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_frame: got byte 0x%02h at cycle %0d, want no frame", got, s0);
        end else begin
          e = exp_q.pop_front();
          check($sformatf("frame_data_%02h", e.data), {24'h0, got}, {24'h0, e.data});
          check($sformatf("frame_start_%02h", e.data), 32'(s0), 32'(e.start));
          check($sformatf("frame_bits_%02h", e.data), {31'h0, shape_ok}, 32'h1);
        end
        mon_busy = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "timeout");
  end

  initial begin : stim
    int p;
    int q;
    int lows;
    bus_if.EN      = 1'b0;
    bus_if.Address = '0;
    bus_if.RegData = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("txd_in_reset", {31'h0, uart_txd}, 32'h1);
    rst = 1'b0;

    // Idle line after reset.
    lows = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (uart_txd !== 1'b1) lows++;
    end
    @(posedge clk);
    #1;
    check("idle_low_cycles", lows, 0);
    read_status(4'h4, "status_after_reset");
    probe(TX_A, 1'b1, "decode_tx");
    probe(BAD_A, 1'b0, "decode_other");

    // Single frame 0xA5: start bit visible on the cycle after the pop edge.
    bus_write(TX_A, 8'hA5, p);
    expect_frame(8'hA5, p + 1);
    wait_to(p + 2);
    read_status(4'h5, "status_mid_a5");
    wait_drain(100, "drain_a5");
    read_status(4'h4, "status_after_a5");

    // Burst of six: first popped at once, four queue, sixth dropped.
    bus_write(TX_A, 8'h01, p);
    expect_frame(8'h01, p + 1);
    for (int i = 2; i <= 6; i++) begin
      bus_write(TX_A, 8'(i), q);
      if (i <= 5) expect_frame(8'(i), p + 1 + 40 * (i - 1));
    end
    read_status(4'hB, "status_burst_ovf");
    bus_write(BAD_A, 8'h08, q);
    read_status(4'hB, "status_after_bad_addr");
    bus_write(ST_A, 8'h08, q);
    read_status(4'h3, "status_after_clear");
    // Push on the exact edge the FSM pops 0x02 out of the full FIFO.
    wait_to(p + 40);
    bus_write(TX_A, 8'h07, q);
    expect_frame(8'h07, p + 1 + 40 * 5);
    read_status(4'h3, "status_push_on_pop");
    wait_drain(400, "drain_burst");
    read_status(4'h4, "status_after_burst");

    // Reset during data bit 3 of 0xFF with two bytes queued and a push on the reset edge.
    bus_write(TX_A, 8'hFF, p);
    expect_frame(8'hFF, p + 1);
    bus_write(TX_A, 8'h11, q);
    bus_write(TX_A, 8'h22, q);
    wait_to(p + 17);
    rst            = 1'b1;
    bus_if.EN      = 1'b1;
    bus_if.Address = TX_A;
    bus_if.RegData = 8'h33;
    @(posedge clk);
    #1;
    bus_if.EN      = 1'b0;
    bus_if.Address = '0;
    bus_if.RegData = '0;
    @(negedge clk);
    check("txd_after_abort", {31'h0, uart_txd}, 32'h1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    read_status(4'h4, "status_after_abort");
    wait_drain(100, "drain_abort");
    repeat (120) @(posedge clk);
    #1;
    check("no_frames_after_abort", exp_q.size(), 0);
    check("monitor_idle_at_end", {31'h0, mon_busy}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_mmio.md
UART_TX_MMIO -- requirements
Module: uart_tx_mmio

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 434, giving clk cycles per serial bit (50 MHz / 115200); legal range 2..65535.
REQ-002 The block SHALL have parameter TX_ADDR, default 32'h0000_0100, the byte address of the transmit-data register.
REQ-003 The block SHALL have parameter STAT_ADDR, default 32'h0000_0104, the byte address of the status register.
REQ-004 clk  input  1  single system clock; all state updates on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 EN  input  1  store strobe from the core's MemWrite.
REQ-007 Address  input  32  ALU-result address of the current load/store.
REQ-008 RegData  input  8  store data, rs2 bits [7:0].
REQ-009 RData_out  output  32  status word, combinational, for the load-result path.
REQ-010 hit  output  1  high when Address equals TX_ADDR or STAT_ADDR.
REQ-011 UART_TXD  output  1  serial line, registered, idle high.

Function
REQ-012 Address decode SHALL use a full 32-bit equality compare.
REQ-013 A push into a 4-entry FIFO SHALL occur on a rising edge where EN=1 and Address=TX_ADDR.
REQ-014 A push into a full FIFO SHALL drop the byte and set the sticky overflow flag.
REQ-015 A push and a pop on the same edge SHALL both take effect, including when the FIFO is full; in that case no overflow is flagged.
REQ-016 FIFO read/write pointers SHALL be 2 bits and wrap modulo 4; occupancy SHALL be a 3-bit count, 0..4.
REQ-017 EN=1 with Address=STAT_ADDR and RegData[3]=1 SHALL clear overflow; a set on the same edge SHALL win.
REQ-018 The FSM SHALL have four states: IDLE, START, DATA, STOP.
REQ-019 IDLE: on the edge where the FIFO is non-empty, pop the head byte into the shift register, go to START, and drive UART_TXD=0.
REQ-020 START: hold 0 for CLKS_PER_BIT cycles, then go to DATA and drive bit0.
REQ-021 DATA: send 8 bits LSB first, each for CLKS_PER_BIT cycles, using a 3-bit bit index, then go to STOP and drive 1.
REQ-022 STOP: hold 1 for CLKS_PER_BIT cycles, then go to IDLE; if the FIFO is non-empty at that edge, go directly to START (back-to-back frames with no extra idle bit).
REQ-023 Each frame SHALL last exactly 10*CLKS_PER_BIT cycles.
REQ-024 The first start-bit cycle SHALL appear 2 edges after the push edge when the FIFO was empty and the FSM idle.
REQ-025 The baud counter SHALL be 16 bits; it reloads to 0 at each bit boundary and counts to CLKS_PER_BIT-1.
REQ-026 RData_out SHALL be {28'b0, overflow, empty, full, busy} when Address=STAT_ADDR, else 32'b0. busy = (state != IDLE).
REQ-027 Loads SHALL have no side effects.
REQ-028 EN with any non-matching address SHALL be ignored.

Reset
REQ-029 On a rst=1 edge: state=IDLE, UART_TXD=1, FIFO flushed (count=0, pointers=0), overflow=0, baud counter=0, bit index=0.
REQ-030 Reset asserted mid-frame SHALL abort the frame; UART_TXD SHALL be 1 from the next cycle, and the aborted byte is lost.
REQ-031 rst SHALL take priority over a push on the same edge.
REQ-032 After reset: RData_out status = 4'b0100 (empty only).

Structure
REQ-033 A shared package SHALL hold the FSM state enum, the default TX_ADDR/STAT_ADDR constants, and the status bit-position constants.
REQ-034 The FIFO SHALL be a sub-module, sync_fifo4x8: push, pop, din, dout, full, empty, count.
REQ-035 The block SHALL sit beside Parallel_OUT on the same store bus, and its hit output SHALL steer the core's load-data mux.

Verification (CLKS_PER_BIT=4)
REQ-036 Reset, then idle 50 cycles -> UART_TXD=1 throughout; status=32'h4.
REQ-037 Push 8'hA5 -> UART_TXD=0 from push edge+2 for 4 cycles; data 1,0,1,0,0,1,0,1 at 4 cycles each; stop 1; 40 cycles total; status=32'h4 afterwards.
REQ-038 Push 6 bytes 8'h01..8'h06 on consecutive edges -> 8'h01 popped immediately, 8'h02..8'h05 queued (full=1), 8'h06 dropped (overflow=1); 5 back-to-back frames of exactly 200 cycles total.
REQ-039 With FIFO full, issue a push on the exact edge the FSM pops -> byte accepted, overflow stays 0, count stays 4.
REQ-040 Assert rst during DATA bit 3 of 8'hFF, with 2 bytes queued -> UART_TXD=1 next cycle; status=32'h4; no further frames.
REQ-041 Write 8'h08 to STAT_ADDR after an overflow -> overflow=0; EN to address 32'h0000_0108 -> no push, status unchanged.
